// File: rtl/demux_pkg.sv
// Shared constants, state names and select-width helper for the 1:N stream demux.
package demux_pkg;

  localparam int N_CH_DEF   = 8;
  localparam int DATA_W_DEF = 1;
  localparam int CNT_W_DEF  = 8;

  // Implicit holding state, derived from the pending mask (never stored separately).
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } dmx_state_e;

  // Select width: enough bits to name every channel, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_decode.sv
// Combinational destination decode: select code / broadcast -> target channel mask.
// An out-of-range select yields an empty mask and raises sel_oor.
module demux_decode
  import demux_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = sel_w(N_CH)
) (
  input  logic [SEL_W-1:0] sel_code,
  input  logic             bcast,
  output logic [N_CH-1:0]  tgt_mask,
  output logic             sel_oor
);

  // Broadcast wins over the select code; otherwise one-hot of an in-range code.
  always_comb begin
    tgt_mask = '0;
    sel_oor  = 1'b0;
    if (bcast) begin
      tgt_mask = '1;
    end else if (int'(sel_code) >= N_CH) begin
      sel_oor = 1'b1;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        tgt_mask[k] = (int'(sel_code) == k);
      end
    end
  end

endmodule

// File: rtl/demux_1_n_stream.sv
// 1:N stream demultiplexer with a single shared output register, a per-channel
// pending mask (independent per-channel handshakes), broadcast support, a sticky
// out-of-range error flag and per-channel wrapping delivery counters.
module demux_1_n_stream
  import demux_pkg::*;
#(
  parameter  int N_CH   = N_CH_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int SEL_W  = sel_w(N_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [DATA_W-1:0]       i_a,
  input  logic [SEL_W-1:0]        i_sel_code,
  input  logic                    i_bcast,
  output logic                    o_ready,
  output logic [DATA_W-1:0]       o_code,
  output logic [N_CH-1:0]         o_valid,
  input  logic [N_CH-1:0]         i_ready,
  output logic                    o_err,
  output logic [N_CH*CNT_W-1:0]   o_cnt
);

  logic [N_CH-1:0]             pend_q;
  logic [N_CH-1:0]             pend_d;
  logic [N_CH-1:0]             tgt_mask;
  logic [N_CH-1:0]             dlv;
  logic [DATA_W-1:0]           code_q;
  logic                        err_q;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_q;
  logic                        sel_oor;
  logic                        drain_all;
  logic                        xfer;
  dmx_state_e                  st;

  demux_decode #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_decode (
    .sel_code (i_sel_code),
    .bcast    (i_bcast),
    .tgt_mask (tgt_mask),
    .sel_oor  (sel_oor)
  );

  // Per-channel deliveries happen wherever a pending bit meets its ready.
  assign dlv       = pend_q & i_ready;
  // Every still-pending channel delivers this cycle, so the register frees up now.
  assign drain_all = ((pend_q & ~i_ready) == '0);
  assign st        = (pend_q == '0) ? ST_EMPTY : ST_HOLD;
  assign o_ready   = (st == ST_EMPTY) || drain_all;
  assign xfer      = i_valid & o_ready;

  assign o_valid = pend_q;
  assign o_code  = code_q;
  assign o_err   = err_q;
  assign o_cnt   = cnt_q;

  // Next pending mask: a new transfer replaces the (fully draining) mask,
  // otherwise delivered channels drop out. Out-of-range items load an empty mask.
  always_comb begin
    pend_d = pend_q & ~i_ready;
    if (xfer) begin
      pend_d = tgt_mask;
    end
  end

  // Output register, pending mask and sticky error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q <= '0;
      code_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      // Discarded items leave the payload register untouched.
      if (xfer && !sel_oor) begin
        code_q <= i_a;
      end
      if (xfer && sel_oor) begin
        err_q <= 1'b1;
      end
    end
  end

  // Per-channel delivery counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (dlv[k]) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Scoreboard bench: stimulus pushes per-channel expected payloads; a negedge
// monitor tracks the item-level reference state and checks every cycle.
module tb_demux_1_n_stream;

  localparam int NC  = 8;
  localparam int DW  = 4;
  localparam int CW  = 8;
  localparam int SW  = 3;
  localparam int NC6 = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (8 channels)
  logic            i_valid = 1'b0;
  logic [DW-1:0]   i_a     = '0;
  logic [SW-1:0]   i_sel   = '0;
  logic            i_bcast = 1'b0;
  logic [NC-1:0]   i_rdy   = '0;
  logic            o_ready;
  logic [DW-1:0]   o_code;
  logic [NC-1:0]   o_valid;
  logic            o_err;
  logic [NC*CW-1:0] o_cnt;

  // range-test instance (6 channels)
  logic            v6 = 1'b0;
  logic [DW-1:0]   a6 = '0;
  logic [SW-1:0]   s6 = '0;
  logic            b6 = 1'b0;
  logic [NC6-1:0]  r6 = '0;
  logic            rdy6;
  logic [DW-1:0]   code6;
  logic [NC6-1:0]  val6;
  logic            err6;
  logic [NC6*CW-1:0] cnt6;

  demux_1_n_stream #(.N_CH(NC), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_a(i_a), .i_sel_code(i_sel),
    .i_bcast(i_bcast), .o_ready(o_ready), .o_code(o_code), .o_valid(o_valid),
    .i_ready(i_rdy), .o_err(o_err), .o_cnt(o_cnt)
  );

  demux_1_n_stream #(.N_CH(NC6), .DATA_W(DW), .CNT_W(CW)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_valid(v6), .i_a(a6), .i_sel_code(s6),
    .i_bcast(b6), .o_ready(rdy6), .o_code(code6), .o_valid(val6),
    .i_ready(r6), .o_err(err6), .o_cnt(cnt6)
  );

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // reference state
  logic [NC-1:0] m_pend = '0;
  logic [DW-1:0] m_code = '0;
  logic [CW-1:0] m_cnt [NC];
  logic [DW-1:0] exp_q [NC][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_item(input logic [SW-1:0] s, input logic b, input logic [DW-1:0] a);
    for (int k = 0; k < NC; k++)
      if (b || int'(s) == k) exp_q[k].push_back(a);
  endtask

  // Present one item and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [SW-1:0] s, input logic b, input logic [DW-1:0] a);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    i_valid = 1'b1; i_sel = s; i_bcast = b; i_a = a;
    while (!ok) begin
      @(negedge clk);
      if (o_ready) ok = 1'b1;
      else begin
        n++;
        if (n > 200) begin
          checks++; failures++;
          $display("FAIL send_timeout: o_ready stuck at 0, required 1 within 200 cycles");
          break;
        end
      end
    end
    if (ok) push_item(s, b, a);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0;
    sync();
    sync();
    rst = 1'b0;
  endtask

  // Monitor: compare DUT against the reference, then advance the reference.
  initial begin
    logic [DW-1:0] d;
    for (int k = 0; k < NC; k++) m_cnt[k] = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("o_valid", o_valid, m_pend);
        chk("o_ready", o_ready, ((m_pend & ~i_rdy) == '0));
        chk("o_code", o_code, m_code);
        chk("o_err", o_err, 1'b0);
        for (int k = 0; k < NC; k++) chk("o_cnt", o_cnt[k*CW +: CW], m_cnt[k]);
      end
      if (rst) begin
        m_pend = '0; m_code = '0;
        for (int k = 0; k < NC; k++) begin m_cnt[k] = '0; exp_q[k].delete(); end
      end else begin
        for (int k = 0; k < NC; k++) begin
          if (m_pend[k] && i_rdy[k]) begin
            if (exp_q[k].size() == 0) begin
              checks++; failures++;
              $display("FAIL deliver_unexpected: channel %0d delivered, required no item", k);
            end else begin
              d = exp_q[k].pop_front();
              if (mon_en) chk("deliver_data", o_code, d);
            end
            m_cnt[k]++;
          end
        end
        if (i_valid && ((m_pend & ~i_rdy) == '0)) begin
          m_pend = '0;
          if (i_bcast) m_pend = '1; else m_pend[i_sel] = 1'b1;
          m_code = i_a;
        end else begin
          m_pend = m_pend & ~i_rdy;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC*CW-1:0] zc;
    zc = '0;
    // reset
    sync(); sync();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_ready", o_ready, 1'b1);
    chk("reset_cnt", o_cnt, zc);

    // single item to channel 3
    sync();
    i_rdy = '1;
    send(3'd3, 1'b0, 4'hA);
    @(negedge clk);
    chk("single_valid", o_valid, 8'h08);
    chk("single_code", o_code, 4'hA);
    @(negedge clk);
    chk("single_cnt3", o_cnt[3*CW +: CW], 8'd1);

    // broadcast, channels released one at a time
    sync();
    i_rdy = '0;
    send(3'd0, 1'b1, 4'h5);
    for (int j = 0; j < NC; j++) begin
      i_rdy = '0; i_rdy[j] = 1'b1;
      @(negedge clk);
      chk("bcast_ready", o_ready, (j == NC - 1));
      sync();
    end
    i_rdy = '0;
    @(negedge clk);
    for (int k = 0; k < NC; k++) chk("bcast_cnt", o_cnt[k*CW +: CW], (k == 3) ? 2 : 1);

    // back-to-back across channels
    sync();
    i_rdy = '1;
    for (int i = 0; i < 16; i++) send(SW'(i % NC), 1'b0, DW'($urandom));
    repeat (2) @(negedge clk);

    // wrap of channel 0 counter after 256 items
    sync();
    do_reset();
    i_rdy = '1;
    for (int i = 0; i < 256; i++) send(3'd0, 1'b0, DW'($urandom));
    repeat (2) @(negedge clk);
    chk("wrap_cnt0", o_cnt[0 +: CW], 8'd0);

    // reset in the middle of a broadcast
    sync();
    i_rdy = '0;
    send(3'd0, 1'b1, 4'h7);
    i_rdy = 8'b0000_0111;
    sync();
    i_rdy = '0;
    @(negedge clk);
    chk("midrst_pending", o_valid, 8'hF8);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", o_valid, 8'h00);
    chk("midrst_ready", o_ready, 1'b1);
    chk("midrst_cnt", o_cnt, zc);

    // backpressure on channel 4
    sync();
    i_rdy = 8'hEF;
    send(3'd4, 1'b0, 4'hC);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_code", o_code, 4'hC);
      chk("bp_ready", o_ready, 1'b0);
    end
    sync();
    i_rdy = '1;
    @(negedge clk);
    chk("bp_release_ready", o_ready, 1'b1);
    @(negedge clk);
    chk("bp_valid", o_valid, 8'h00);
    chk("bp_cnt4", o_cnt[4*CW +: CW], 8'd1);

    // randomized traffic
    sync();
    for (int i = 0; i < 1500; i++) begin
      i_rdy   = NC'($urandom);
      i_valid = 1'($urandom_range(0, 1));
      i_sel   = SW'($urandom);
      i_bcast = ($urandom_range(0, 7) == 0);
      i_a     = DW'($urandom);
      @(negedge clk);
      if (i_valid && o_ready) push_item(i_sel, i_bcast, i_a);
      sync();
    end
    i_valid = 1'b0;
    i_rdy   = '1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NC; k++) chk("drain_empty", exp_q[k].size(), 0);

    // out-of-range select on the 6-channel instance
    sync();
    r6 = '1; v6 = 1'b1; s6 = 3'd7; a6 = 4'h3;
    @(negedge clk);
    chk("oor_accept", rdy6, 1'b1);
    sync();
    v6 = 1'b0;
    @(negedge clk);
    chk("oor_valid", val6, 6'b0);
    chk("oor_err", err6, 1'b1);
    chk("oor_code", code6, 4'h0);
    sync();
    v6 = 1'b1; s6 = 3'd6; a6 = 4'h5;
    sync();
    v6 = 1'b0;
    @(negedge clk);
    chk("oor6_valid", val6, 6'b0);
    chk("oor6_code", code6, 4'h0);
    sync();
    v6 = 1'b1; s6 = 3'd2; a6 = 4'h9;
    sync();
    v6 = 1'b0;
    @(negedge clk);
    chk("after_oor_valid", val6, 6'b000100);
    chk("after_oor_code", code6, 4'h9);
    chk("err_sticky", err6, 1'b1);
    @(negedge clk);
    chk("after_oor_cnt2", cnt6[2*CW +: CW], 8'd1);
    chk("after_oor_drained", val6, 6'b0);
    chk("err_sticky2", err6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
